// File: rtl/snake_dir_if.sv
// snake_dir_ctrl key/step inputs and heading outputs.
// master drives keys and game control; slave is the controller.
interface snake_dir_if;
    logic       key_up;
    logic       key_down;
    logic       key_left;
    logic       key_right;
    logic       game_run;
    logic       game_clr;
    logic       step_tick;
    logic [1:0] dir;
    logic       dir_upd;
    logic       req_drop;
    logic [1:0] q_cnt;

    modport master (
        output key_up, key_down, key_left, key_right,
        output game_run, game_clr, step_tick,
        input  dir, dir_upd, req_drop, q_cnt
    );

    modport slave (
        input  key_up, key_down, key_left, key_right,
        input  game_run, game_clr, step_tick,
        output dir, dir_upd, req_drop, q_cnt
    );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Snake heading controller: round-robin key arbitration, reversal filter,
// pending-request buffer. SNAKE_DIR_QUEUE_EN selects the 2-entry FIFO.
module snake_dir_ctrl #(
    parameter logic [1:0] INIT_DIR = 2'b11
) (
    input  logic       clk,
    input  logic       rst_n,
    snake_dir_if.slave bus
);
    localparam logic [1:0] D_UP = 2'b00;

    logic [3:0] req;
    logic       act;
    logic       any_req;
    logic       multi;
    logic       legal;
    logic       push;
    logic       pop;
    logic [1:0] win;
    logic [1:0] tail;
    logic [1:0] arb_idx;
    logic       arb_found;

    logic [1:0] rr_q;
    logic [1:0] dir_q, dir_d;
    logic [1:0] cnt_q, cnt_d;
    logic       upd_q;
    logic       drop_q, drop_d;

    // Bit index of req equals the heading code of that key.
    assign req = {bus.key_right, bus.key_left,
                  bus.key_down, bus.key_up};
    assign act = bus.game_run & ~bus.game_clr;
    assign any_req = act & (|req);
    assign multi = (req & (req - 4'd1)) != 4'd0;

    always_comb begin
        win       = rr_q;
        arb_found = 1'b0;
        arb_idx   = rr_q;
        for (int i = 0; i < 4; i++) begin
            arb_idx = rr_q + 2'(i);
            if (!arb_found && req[arb_idx]) begin
                win       = arb_idx;
                arb_found = 1'b1;
            end
        end
    end

    assign legal = (win != tail) && (win != {tail[1], ~tail[0]});

`ifdef SNAKE_DIR_QUEUE_EN
    logic [1:0] q0_q, q0_d;
    logic [1:0] q1_q, q1_d;
    logic [1:0] cnt_pp;

    assign tail = (cnt_q == 2'd0) ? dir_q :
                  (cnt_q == 2'd1) ? q0_q  : q1_q;
    assign pop  = act & bus.step_tick & (cnt_q != 2'd0);
    assign push = any_req & legal & ((cnt_q != 2'd2) | pop);

    always_comb begin
        cnt_pp = cnt_q - {1'b0, pop};
        q0_d   = pop ? q1_q : q0_q;
        q1_d   = q1_q;
        if (push) begin
            if (cnt_pp == 2'd0) q0_d = win;
            else                q1_d = win;
        end
        cnt_d = cnt_pp + {1'b0, push};
        dir_d = pop ? q0_q : dir_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0_q <= D_UP;
            q1_q <= D_UP;
        end else begin
            q0_q <= q0_d;
            q1_q <= q1_d;
        end
    end
`else
    logic [1:0] pend_q, pend_d;

    // Single pending slot: newest legal request overwrites.
    assign tail = dir_q;
    assign pop  = act & bus.step_tick & cnt_q[0];
    assign push = any_req & legal;

    always_comb begin
        pend_d = push ? win : pend_q;
        cnt_d  = {1'b0, push | (cnt_q[0] & ~pop)};
        dir_d  = pop ? pend_q : dir_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= D_UP;
        else        pend_q <= pend_d;
    end
`endif

    assign drop_d = (act & multi) | (any_req & ~push);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q   <= D_UP;
            dir_q  <= INIT_DIR;
            cnt_q  <= 2'd0;
            upd_q  <= 1'b0;
            drop_q <= 1'b0;
        end else if (bus.game_clr) begin
            rr_q   <= D_UP;
            dir_q  <= INIT_DIR;
            cnt_q  <= 2'd0;
            upd_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            if (any_req) rr_q <= win + 2'd1;
            dir_q  <= dir_d;
            cnt_q  <= cnt_d;
            upd_q  <= pop;
            drop_q <= drop_d;
        end
    end

    assign bus.dir      = dir_q;
    assign bus.dir_upd  = upd_q;
    assign bus.req_drop = drop_q;
    assign bus.q_cnt    = cnt_q;
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Scoreboard bench for snake_dir_ctrl against a queue-based model.
// Follows SNAKE_DIR_QUEUE_EN the same way as the design.
`timescale 1ns/1ps
module tb_snake_dir_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  snake_dir_if bus();

  snake_dir_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] dir;
    logic       upd;
    logic       drop;
    logic [1:0] cnt;
  } exp_t;

`ifdef SNAKE_DIR_QUEUE_EN
  localparam int QDEPTH = 2;
`else
  localparam int QDEPTH = 1;
`endif

  localparam logic [3:0] K_NO = 4'b0000;
  localparam logic [3:0] K_UP = 4'b0001;
  localparam logic [3:0] K_DN = 4'b0010;
  localparam logic [3:0] K_LT = 4'b0100;
  localparam logic [3:0] K_RT = 4'b1000;

  exp_t exp_q[$];
  int vectors = 0;
  int errors = 0;

  logic [1:0] mdir;
  int         mrr;
  logic [1:0] mq[$];

  task automatic model(input logic [3:0] k, input logic st,
                       input logic run, input logic clr,
                       input logic rst, output exp_t e);
    int nreq;
    int win;
    logic [1:0] tl;
    logic [1:0] w2;
    bit do_pop;
    bit accept;
    e.upd  = 1'b0;
    e.drop = 1'b0;
    if (rst || clr) begin
      mdir = 2'b11;
      mq.delete();
      mrr = 0;
    end else if (run) begin
      nreq = $countones(k);
      win = -1;
      for (int i = 0; i < 4; i++) begin
        if (win < 0 && k[(mrr + i) % 4]) win = (mrr + i) % 4;
      end
      if (nreq > 1) e.drop = 1'b1;
      tl = (QDEPTH == 1 || mq.size() == 0) ? mdir : mq[$];
      do_pop = st && (mq.size() > 0);
      accept = 0;
      if (win >= 0) begin
        w2 = 2'(win);
        mrr = (win + 1) % 4;
        if (w2 != tl && w2 != (tl ^ 2'b01) &&
            (QDEPTH == 1 || mq.size() < 2 || do_pop))
          accept = 1;
        else
          e.drop = 1'b1;
      end
      if (do_pop) begin
        mdir = mq.pop_front();
        e.upd = 1'b1;
      end
      if (accept) begin
        if (QDEPTH == 1) mq.delete();
        mq.push_back(w2);
      end
    end
    e.dir = mdir;
    e.cnt = 2'(mq.size());
  endtask

  task automatic cyc(input logic [3:0] k, input logic st,
                     input logic run, input logic clr,
                     input logic rst);
    exp_t e;
    @(negedge clk);
    bus.key_up    = k[0];
    bus.key_down  = k[1];
    bus.key_left  = k[2];
    bus.key_right = k[3];
    bus.step_tick = st;
    bus.game_run  = run;
    bus.game_clr  = clr;
    rst_n = ~rst;
    model(k, st, run, clr, rst, e);
    exp_q.push_back(e);
  endtask

  task automatic go(input logic [3:0] k, input logic st);
    cyc(k, st, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [1:0] act,
                     input logic [1:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               nm, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dir", bus.dir, e.dir);
        chk("dir_upd", {1'b0, bus.dir_upd}, {1'b0, e.upd});
        chk("req_drop", {1'b0, bus.req_drop}, {1'b0, e.drop});
        chk("q_cnt", bus.q_cnt, e.cnt);
      end
    end
  end

  initial begin : stim
    logic [3:0] k;
    bus.key_up = 0; bus.key_down = 0;
    bus.key_left = 0; bus.key_right = 0;
    bus.step_tick = 0; bus.game_run = 1; bus.game_clr = 0;
    mdir = 2'b11; mrr = 0;

    // reset state
    repeat (3) cyc(K_NO, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (10) go(K_NO, 1'b0);

    // queued turn
    go(K_UP, 0); go(K_NO, 0); go(K_NO, 0);
    go(K_LT, 0); go(K_NO, 0);
    go(K_NO, 1); go(K_NO, 0);
    go(K_NO, 1); go(K_NO, 0);

    // reversal, repeat, full drops
    cyc(K_NO, 0, 1, 1, 0);
    go(K_LT, 0); go(K_NO, 0);
    go(K_RT, 0); go(K_NO, 0);
    go(K_UP, 0); go(K_LT, 0); go(K_DN, 0); go(K_NO, 0);
    repeat (3) go(K_NO, 1);

    // push and pop in the same cycle
    cyc(K_NO, 0, 1, 1, 0);
    go(K_UP, 0); go(K_LT, 0);
    go(K_DN, 1); go(K_NO, 0);
    repeat (3) go(K_NO, 1);

    // round-robin from dir LEFT, rr UP
    cyc(K_NO, 0, 1, 1, 0);
    go(K_UP, 0); go(K_NO, 1);
    go(K_LT, 0); go(K_NO, 1);
    go(K_RT, 0); go(K_NO, 0);
    repeat (3) begin
      go(K_UP | K_DN, 0); go(K_NO, 0);
      go(K_NO, 1); go(K_NO, 0);
    end

    // game_run low, then game_clr with key and tick
    cyc(K_NO, 0, 1, 1, 0);
    go(K_UP, 0);
    cyc(K_LT, 1, 0, 0, 0);
    cyc(K_UP | K_DN, 1, 0, 0, 0);
    cyc(K_NO, 1, 0, 0, 0);
    go(K_LT, 0);
    cyc(K_UP, 1, 1, 1, 0);
    go(K_NO, 0);
    cyc(K_DN, 1, 0, 1, 0);
    go(K_NO, 0);

    // last wins vs. reversal drop
    go(K_UP, 0); go(K_DN, 0); go(K_NO, 1); go(K_NO, 0);

    // mid-operation reset
    go(K_UP, 0); go(K_LT, 0);
    cyc(K_NO, 1, 1, 0, 1);
    go(K_NO, 0); go(K_NO, 1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      k = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      cyc(k, 1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 9) != 0),
          1'($urandom_range(0, 49) == 0),
          1'($urandom_range(0, 299) == 0));
    end
    go(K_NO, 0);

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      vectors++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
